// File: rtl/fp_mac_pkg.sv
// Shared FP MAC datapath definitions: FP32 fields, special-case
// encoding and status flag bit positions.
package fp_mac_pkg;

    localparam int FP_EXP_W  = 8;
    localparam int FP_FRAC_W = 23;
    localparam int FP_MANT_W = FP_FRAC_W + 1;
    localparam int FP_BIAS   = 127;

    localparam logic [31:0] FP_QNAN = 32'h7FC0_0000;

    typedef enum logic [1:0] {
        SPC_NORMAL = 2'b00,
        SPC_ZERO   = 2'b01,
        SPC_INF    = 2'b10,
        SPC_NAN    = 2'b11
    } special_e;

    localparam int FLAG_W   = 3;
    localparam int FLAG_INX = 0;
    localparam int FLAG_UNF = 1;
    localparam int FLAG_OVF = 2;

endpackage

// File: rtl/mitchell_product_normalizer_if.sv
// Valid/ready bundle between the multiplier, the normalizer
// and the accumulator adder.
interface mitchell_product_normalizer_if
    import fp_mac_pkg::*;
#(
    parameter int MANT_WIDTH = FP_MANT_W,
    parameter int EXP_WIDTH  = FP_EXP_W
);

    logic                            in_valid;
    logic                            in_ready;
    logic [2*MANT_WIDTH-1:0]         in_product;
    logic [EXP_WIDTH-1:0]            in_exp_a;
    logic [EXP_WIDTH-1:0]            in_exp_b;
    logic                            in_sign;
    logic [1:0]                      in_special;
    logic                            out_valid;
    logic                            out_ready;
    logic [EXP_WIDTH+MANT_WIDTH-1:0] out_result;
    logic [FLAG_W-1:0]               out_flags;

    modport master (
        output in_valid, in_product, in_exp_a, in_exp_b,
        output in_sign, in_special, out_ready,
        input  in_ready, out_valid, out_result, out_flags
    );

    modport slave (
        input  in_valid, in_product, in_exp_a, in_exp_b,
        input  in_sign, in_special, out_ready,
        output in_ready, out_valid, out_result, out_flags
    );

endinterface

// File: rtl/mitchell_product_normalizer_lod.sv
// Leading-one priority encoder: position of the highest set bit
// and a flag for an all-zero vector.
module lead_one_detect #(
    parameter int W     = 48,
    parameter int POS_W = $clog2(W)
) (
    input  logic [W-1:0]     vec,
    output logic [POS_W-1:0] pos,
    output logic             zero
);

    always_comb begin
        pos  = '0;
        zero = 1'b1;
        for (int i = 0; i < W; i++) begin
            if (vec[i]) begin
                pos  = POS_W'(i);
                zero = 1'b0;
            end
        end
    end

endmodule

// File: rtl/mitchell_product_normalizer.sv
// Two-stage normalize / round-to-nearest-even / pack stage turning
// an approximate mantissa product into an FP32 result with flags.
module mitchell_product_normalizer
    import fp_mac_pkg::*;
#(
    parameter int MANT_WIDTH = FP_MANT_W,
    parameter int EXP_WIDTH  = FP_EXP_W,
    parameter int BIAS       = FP_BIAS
) (
    input  logic clk,
    input  logic rst_n,
    mitchell_product_normalizer_if.slave io
);

    localparam int PW = 2 * MANT_WIDTH;
    localparam int LW = $clog2(PW);
    localparam int EW = EXP_WIDTH + 3;
    localparam int FW = MANT_WIDTH - 1;
    localparam int RW = EXP_WIDTH + MANT_WIDTH;

    localparam logic signed [EW-1:0] E_MAX =
        EW'((1 << EXP_WIDTH) - 1);
    localparam logic signed [EW-1:0] E_ZERO = '0;

    // The hidden bit is always 1 after normalization, so only
    // bits below it are carried into stage 2.
    typedef struct packed {
        logic          sign;
        special_e      spc;
        logic [EW-1:0] exp;
        logic [PW-2:0] mant;
    } norm_t;

    logic          s1_valid;
    logic          s2_valid;
    logic          s2_free;
    logic          s1_adv;
    norm_t         s1_d;
    norm_t         s1_q;
    logic [LW-1:0] lead_pos;
    logic          prod_zero;
    special_e      spc_in;
    logic [RW-1:0] res_d;
    logic [RW-1:0] res_q;
    logic [FLAG_W-1:0] flg_d;
    logic [FLAG_W-1:0] flg_q;

    assign s2_free = !s2_valid || io.out_ready;
    assign s1_adv  = !s1_valid || s2_free;

    assign io.in_ready   = s1_adv;
    assign io.out_valid  = s2_valid;
    assign io.out_result = res_q;
    assign io.out_flags  = flg_q;

    lead_one_detect #(
        .W     (PW),
        .POS_W (LW)
    ) u_lod (
        .vec  (io.in_product),
        .pos  (lead_pos),
        .zero (prod_zero)
    );

    assign spc_in = special_e'(io.in_special);

    always_comb begin
        s1_d      = '0;
        s1_d.sign = io.in_sign;
        s1_d.spc  = (spc_in == SPC_NORMAL && prod_zero)
                  ? SPC_ZERO : spc_in;
        s1_d.exp  = EW'(io.in_exp_a) + EW'(io.in_exp_b)
                  + EW'(lead_pos) - EW'(BIAS) - EW'(PW - 2);
        s1_d.mant = (PW-1)'(io.in_product
                  << (LW'(PW - 1) - lead_pos));
    end

    logic [FW-1:0]        frac;
    logic                 guard;
    logic                 sticky;
    logic                 lsb;
    logic                 rnd;
    logic [FW:0]          frac_sum;
    logic signed [EW-1:0] e_adj;
    logic                 ovf;
    logic                 unf;

    always_comb begin
        frac     = s1_q.mant[PW-2 -: FW];
        guard    = s1_q.mant[PW-1-MANT_WIDTH];
        sticky   = |s1_q.mant[PW-2-MANT_WIDTH:0];
        lsb      = s1_q.mant[PW-MANT_WIDTH];
        rnd      = guard && (sticky || lsb);
        frac_sum = {1'b0, frac} + {{FW{1'b0}}, rnd};
        e_adj    = s1_q.exp + EW'(frac_sum[FW]);
        ovf      = (e_adj >= E_MAX);
        unf      = (e_adj <= E_ZERO);
    end

    always_comb begin
        res_d = '0;
        flg_d = '0;
        unique case (s1_q.spc)
            SPC_NAN:  res_d = FP_QNAN;
            SPC_INF:  res_d = {s1_q.sign, {EXP_WIDTH{1'b1}},
                               {FW{1'b0}}};
            SPC_ZERO: res_d = {s1_q.sign, {(RW-1){1'b0}}};
            SPC_NORMAL: begin
                flg_d[FLAG_INX] = guard || sticky;
                unique case (1'b1)
                    ovf: begin
                        res_d = {s1_q.sign, {EXP_WIDTH{1'b1}},
                                 {FW{1'b0}}};
                        flg_d[FLAG_OVF] = 1'b1;
                    end
                    unf: begin
                        res_d = {s1_q.sign, {(RW-1){1'b0}}};
                        flg_d[FLAG_UNF] = 1'b1;
                    end
                    default: begin
                        res_d = {s1_q.sign,
                                 e_adj[EXP_WIDTH-1:0],
                                 frac_sum[FW-1:0]};
                    end
                endcase
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_valid <= 1'b0;
            s1_q     <= '0;
        end else if (s1_adv) begin
            s1_valid <= io.in_valid;
            if (io.in_valid) s1_q <= s1_d;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s2_valid <= 1'b0;
            res_q    <= '0;
            flg_q    <= '0;
        end else if (s2_free) begin
            s2_valid <= s1_valid;
            if (s1_valid) begin
                res_q <= res_d;
                flg_q <= flg_d;
            end
        end
    end

endmodule
